// File: rtl/mem_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dma_pkg
//  Purpose  : Shared definitions for the mem_dma block: default widths and
//             the transfer state enumeration.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_dma_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage : mem_dma_pkg
`default_nettype wire

// File: rtl/mem_dma.sv
`default_nettype none
// ============================================================================
//  Module   : mem_dma
//  Purpose  : Word-at-a-time memory DMA engine. Copies length words from
//             src_addr to dst_addr (read/write alternating), or fills
//             length words at dst_addr with fill_value.
//  Ports    : clk, reset (async, active high)
//             start, fill, src_addr, dst_addr, length, fill_value  - request
//             busy, done                                           - status
//             address, write_data, mem_write, mem_read, read_data  - memory
//  Revision : 1.0 - initial release
// ============================================================================
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fill,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] read_data
);

    state_e            state_q,  state_d;
    logic [ADDR_W-1:0] src_q,    src_d;
    logic [ADDR_W-1:0] dst_q,    dst_d;
    logic [ADDR_W-1:0] len_q,    len_d;
    logic              fill_q,   fill_d;
    logic [DATA_W-1:0] fillv_q,  fillv_d;
    logic [ADDR_W-1:0] count_q,  count_d;
    logic [DATA_W-1:0] data_q,   data_d;

    // Incremented count kept at ADDR_W bits so the last-word compare and
    // address arithmetic both wrap modulo 2^ADDR_W.
    logic [ADDR_W-1:0] w_count_inc;
    assign w_count_inc = count_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        fill_d     = fill_q;
        fillv_d    = fillv_q;
        count_d    = count_q;
        data_d     = data_q;
        address    = '0;
        write_data = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = length;
                    fill_d  = fill;
                    fillv_d = fill_value;
                    count_d = '0;
                    if (length == '0)
                        state_d = ST_DONE;
                    else if (fill)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                address  = src_q + count_q;
                mem_read = 1'b1;
                data_d   = read_data;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                address    = dst_q + count_q;
                mem_write  = 1'b1;
                write_data = fill_q ? fillv_q : data_q;
                count_d    = w_count_inc;
                if (w_count_inc == len_q)
                    state_d = ST_DONE;
                else if (fill_q)
                    state_d = ST_WRITE;
                else
                    state_d = ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= 1'b0;
            fillv_q <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            fillv_q <= fillv_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule : mem_dma
`default_nettype wire

// File: tb/tb_mem_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_dma
//  Purpose  : Self-checking bench for mem_dma. Holds the data memory model;
//             expected memory accesses and done pulses are queued as stimulus
//             is issued and a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dma;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam int K_READ  = 0;
    localparam int K_WRITE = 1;
    localparam int K_DONE  = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic              fill;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] length;
    logic [DATA_W-1:0] fill_value;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] read_data;

    // Data memory model with a preload port for the stimulus.
    logic [DATA_W-1:0] mem [256];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    assign read_data = mem[address];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_write)
            mem[address] <= write_data;
    end

    mem_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fill       (fill),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .address    (address),
        .write_data (write_data),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic push(input int kind, input int addr, input int data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every memory access and done pulse must match the queue head.
    always @(negedge clk) begin
        ev_t e;
        int  kind;
        chk("rd_wr_exclusive", int'(mem_read & mem_write), 0);
        if (!mem_read && !mem_write) begin
            chk("idle_address_zero", int'(address), 0);
            chk("idle_wdata_zero", int'(write_data), 0);
        end
        if (mem_read || mem_write || done) begin
            kind = mem_read ? K_READ : (mem_write ? K_WRITE : K_DONE);
            if (exp_q.size() == 0) begin
                chk("unexpected_event_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                if (kind != K_DONE)
                    chk("event_addr", int'(address), e.addr);
                if (kind == K_WRITE)
                    chk("event_wdata", int'(write_data), e.data);
            end
        end
    end

    task automatic poke(input int a, input int d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = ADDR_W'(a);
        pl_data = DATA_W'(d);
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Presents a request in an idle cycle; returns just after the accepting edge.
    task automatic issue(input logic f, input int s, input int d, input int len,
                         input int fv);
        @(negedge clk);
        chk("idle_before_start", int'(busy), 0);
        start      = 1'b1;
        fill       = f;
        src_addr   = ADDR_W'(s);
        dst_addr   = ADDR_W'(d);
        length     = ADDR_W'(len);
        fill_value = DATA_W'(fv);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles after acceptance until done is seen, starting at offset.
    task automatic wait_done(input string nm, input int offset, input int expc);
        int got;
        got = -1;
        for (int c = offset + 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                got = c;
                break;
            end
        end
        chk({nm, "_done_latency"}, got, expc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        fill       = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        length     = '0;
        fill_value = '0;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = '0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_mem_read", int'(mem_read), 0);
        chk("reset_mem_write", int'(mem_write), 0);
        chk("reset_address", int'(address), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Copy of two words.
        poke(10, 55);
        poke(11, 100);
        push(K_READ, 10, 0);  push(K_WRITE, 40, 55);
        push(K_READ, 11, 0);  push(K_WRITE, 41, 100);
        push(K_DONE, 0, 0);
        issue(1'b0, 10, 40, 2, 0);
        chk("copy_busy_after_accept", int'(busy), 1);
        wait_done("copy", 0, 5);
        chk("copy_busy_in_done", int'(busy), 1);
        chk("copy_mem40", int'(mem[40]), 55);
        chk("copy_mem41", int'(mem[41]), 100);

        // Fill of three words; the word after the range must survive.
        poke(23, 8'h33);
        push(K_WRITE, 20, 8'hA5); push(K_WRITE, 21, 8'hA5);
        push(K_WRITE, 22, 8'hA5); push(K_DONE, 0, 0);
        issue(1'b1, 0, 20, 3, 8'hA5);
        wait_done("fill", 0, 4);
        chk("fill_mem20", int'(mem[20]), 8'hA5);
        chk("fill_mem22", int'(mem[22]), 8'hA5);
        chk("fill_mem23", int'(mem[23]), 8'h33);

        // Source range wrapping past the top of memory.
        poke(254, 8'h01);
        poke(255, 8'h02);
        poke(0,   8'h03);
        push(K_READ, 254, 0); push(K_WRITE, 30, 1);
        push(K_READ, 255, 0); push(K_WRITE, 31, 2);
        push(K_READ, 0,   0); push(K_WRITE, 32, 3);
        push(K_DONE, 0, 0);
        issue(1'b0, 254, 30, 3, 0);
        wait_done("wrap", 0, 7);
        chk("wrap_mem32", int'(mem[32]), 3);

        // Zero length: done only, no memory traffic.
        push(K_DONE, 0, 0);
        issue(1'b0, 5, 6, 0, 0);
        wait_done("zero_len", 0, 1);

        // Start while busy, with operands changing after acceptance.
        poke(90, 8'h77);
        poke(91, 8'h77);
        push(K_READ, 10, 0);  push(K_WRITE, 60, 55);
        push(K_READ, 11, 0);  push(K_WRITE, 61, 100);
        push(K_DONE, 0, 0);
        issue(1'b0, 10, 60, 2, 0);
        start      = 1'b1;
        fill       = 1'b1;
        src_addr   = 8'd0;
        dst_addr   = 8'd90;
        length     = 8'd9;
        fill_value = 8'hEE;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 2, 5);
        @(negedge clk);
        chk("busy_start_mem90", int'(mem[90]), 8'h77);
        chk("busy_start_mem91", int'(mem[91]), 8'h77);
        chk("busy_start_mem61", int'(mem[61]), 100);

        // Reset after the second write of a four-word copy.
        poke(100, 8'h11); poke(101, 8'h22);
        poke(102, 8'h33); poke(103, 8'h44);
        poke(72, 8'hEE);  poke(73, 8'hEE);
        push(K_READ, 100, 0); push(K_WRITE, 70, 8'h11);
        push(K_READ, 101, 0); push(K_WRITE, 71, 8'h22);
        issue(1'b0, 100, 70, 4, 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_read", int'(mem_read), 0);
        chk("rst_mid_address", int'(address), 0);
        chk("rst_mid_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_done", int'(done), 0);
        end
        chk("rst_mid_queue_drained", exp_q.size(), 0);
        chk("rst_mid_mem72", int'(mem[72]), 8'hEE);
        chk("rst_mid_mem73", int'(mem[73]), 8'hEE);
        chk("rst_mid_mem71", int'(mem[71]), 8'h22);

        // First start after reset release is accepted on the first edge.
        push(K_DONE, 0, 0);
        reset    = 1'b0;
        start    = 1'b1;
        fill     = 1'b0;
        length   = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("post_reset", 0, 1);

        repeat (4) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_dma
`default_nettype wire

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the data-memory address width and the length field width.
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the data-memory word width.
REQ-003 Port clk  input  1  -- single clock; all state SHALL change on its rising edge only.
REQ-004 Port reset  input  1  -- asynchronous, active-high reset.
REQ-005 Port start  input  1  -- request a transfer; sampled only in IDLE.
REQ-006 Port fill  input  1  -- transfer mode: 0 = copy src to dst; 1 = write fill_value to dst.
REQ-007 Port src_addr  input  ADDR_W  -- copy source base address.
REQ-008 Port dst_addr  input  ADDR_W  -- destination base address.
REQ-009 Port length  input  ADDR_W  -- number of words, 0..2^ADDR_W-1.
REQ-010 Port fill_value  input  DATA_W  -- word written in fill mode.
REQ-011 Port busy  output  1  -- high from the cycle after an accepted start through the DONE cycle.
REQ-012 Port done  output  1  -- one-cycle completion pulse.
REQ-013 Port address  output  ADDR_W  -- data-memory address.
REQ-014 Port write_data  output  DATA_W  -- data-memory write word.
REQ-015 Port mem_write  output  1  -- data-memory write enable.
REQ-016 Port mem_read  output  1  -- data-memory read enable.
REQ-017 Port read_data  input  DATA_W  -- data-memory read word; combinational, valid in the same cycle mem_read is high.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, READ, WRITE, DONE.
REQ-019 In IDLE, start=1 SHALL latch src_addr, dst_addr, length, fill and fill_value, and clear the word counter.
- Next state: DONE if length=0; else WRITE if fill=1; else READ.
REQ-020 In READ, the block SHALL drive address=src+count and mem_read=1, and SHALL capture read_data into a data register at the clock edge ending the cycle; next state is WRITE.
REQ-021 In WRITE, the block SHALL drive address=dst+count, mem_write=1 and write_data, then increment count.
- write_data = data register (copy mode) or latched fill_value (fill mode).
- Next state: DONE when count+1 equals length; else READ (copy) or WRITE (fill).
REQ-022 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE.
REQ-023 Address arithmetic SHALL wrap modulo 2^ADDR_W; a wrap SHALL raise no error.
REQ-024 mem_read and mem_write SHALL never be high in the same cycle.
- Both SHALL be 0 in IDLE and DONE.
REQ-025 address and write_data SHALL be 0 whenever neither enable is high.
REQ-026 Transfer time from start acceptance to the done cycle inclusive:
- copy: 2*length+1 cycles;
- fill: length+1 cycles;
- length=0: 1 cycle, with no memory access.
REQ-027 start while busy=1 SHALL be ignored; the in-flight transfer SHALL run to completion with its latched operands.
REQ-028 Changes on src_addr, dst_addr, length, fill or fill_value after acceptance SHALL have no effect.
REQ-029 Overlapping source and destination ranges SHALL be processed in ascending address order with no overlap detection.
REQ-030 start held high through DONE SHALL be accepted again in the following IDLE cycle.

Reset
REQ-031 Asserting reset SHALL immediately, without waiting for clk, force:
- state to IDLE;
- busy, done, mem_write and mem_read to 0;
- address, write_data, counter, data register and latched operands to 0.
REQ-032 Reset during a transfer SHALL abandon it: no done pulse, and no further memory access after reset.
REQ-033 The first start after reset deasserts SHALL be accepted on the first rising clk edge at which reset is low.

Structure
REQ-034 Shared package mem_dma_pkg SHALL contain the state enumeration and the ADDR_W and DATA_W default constants.
REQ-035 The design SHALL be a single module with no sub-module; data_memory SHALL be instantiated only in the testbench.

Verification
REQ-036 Copy: memory[10]=55, memory[11]=100; start with src=10, dst=40, length=2, fill=0.
- Required: memory[40]=55 and memory[41]=100.
- done exactly 5 cycles after acceptance.
- Enable sequence: R, W, R, W.
REQ-037 Fill: dst=20, length=3, fill_value=8'hA5.
- Required: memory[20..22]=A5 and memory[23] unchanged.
- done 4 cycles after acceptance.
REQ-038 Wrap: copy with src=254, dst=30, length=3.
- Required: reads at 254, 255, 0; writes at 30, 31, 32.
REQ-039 Zero length: start with length=0.
- Required: done on the next cycle; mem_read and mem_write stay 0.
REQ-040 Busy start: a second start (dst=90) issued mid-transfer.
- Required: it is ignored; only the first transfer's addresses are written.
REQ-041 Reset after the second WRITE of a length-4 copy.
- Required: outputs 0 immediately, no done pulse, memory[dst+2..dst+3] unchanged.
